axi_burst_addr_gen: RTL

Parametrised AXI4 burst address generator. It latches a burst descriptor (start address, length, size, burst type) and produces one beat address per accepted beat, with a last-beat flag. It supports the FIXED, INCR and WRAP burst types, and checks descriptors for 4 KB-boundary and WRAP legality. It sits between a cache/LSU request front-end and the AXI master channel logic, and generalises the plain +4 incrementer to full AXI burst semantics.

---
 rtl/axi_burst_addr_gen_pkg.sv | 27 ++
 rtl/axi_burst_addr_gen_check.sv | 63 ++++++
 rtl/axi_burst_addr_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared types and helpers for the AXI burst address generator.
//   burst_e       : AXI AxBURST encodings
//   state_e       : generator control states
//   BOUNDARY_DEFAULT : region an INCR burst may not cross (bytes)
//   size_to_bytes : AxSIZE -> bytes per beat
package axi_burst_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam int BOUNDARY_DEFAULT = 4096;

    // AxSIZE is log2 of the beat size; the widest legal AXI beat is 128 bytes
    function automatic logic [7:0] size_to_bytes(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen_check.sv
// Combinational legality check of an incoming AXI burst descriptor.
//   addr  : burst start address
//   len   : beats minus one (AxLEN)
//   size  : log2 bytes per beat (AxSIZE)
//   burst : burst type (AxBURST)
//   legal : 1 when the descriptor may be executed
module axi_burst_check
    import axi_burst_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int LEN_WIDTH      = 8,
    parameter int BOUNDARY_BYTES = BOUNDARY_DEFAULT
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic [2:0]                size,
    input  logic [1:0]                burst,
    output logic                      legal
);

    localparam logic [AXI_ADDR_WIDTH-1:0] ONE_A      = AXI_ADDR_WIDTH'(1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BOUND_MASK =
        ~(AXI_ADDR_WIDTH'(BOUNDARY_BYTES) - ONE_A);

    logic [7:0]                beat_bytes_s;
    logic [AXI_ADDR_WIDTH-1:0] incr_s;
    logic [AXI_ADDR_WIDTH-1:0] aligned_s;
    logic [AXI_ADDR_WIDTH-1:0] span_s;
    logic [AXI_ADDR_WIDTH-1:0] last_byte_s;
    logic                      size_bad_s;
    logic                      wrap_len_bad_s;
    logic                      wrap_align_bad_s;
    logic                      incr_cross_s;
    logic                      fixed_len_bad_s;

    assign beat_bytes_s = size_to_bytes(size);
    assign incr_s       = AXI_ADDR_WIDTH'(beat_bytes_s);
    assign aligned_s    = addr & ~(incr_s - ONE_A);
    assign span_s       = incr_s * (AXI_ADDR_WIDTH'(len) + ONE_A);
    // Last byte touched by an INCR burst; the first beat may be unaligned
    // but the burst still occupies whole beats from the aligned base.
    assign last_byte_s  = aligned_s + span_s - ONE_A;

    assign size_bad_s       = {24'd0, beat_bytes_s} > 32'(AXI_DATA_WIDTH / 8);
    assign wrap_len_bad_s   = !((len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                                (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15)));
    assign wrap_align_bad_s = (addr & (incr_s - ONE_A)) != {AXI_ADDR_WIDTH{1'b0}};
    assign incr_cross_s     = (last_byte_s & BOUND_MASK) != (addr & BOUND_MASK);
    assign fixed_len_bad_s  = len > LEN_WIDTH'(15);

    // Fold the per-type rules into a single legal flag
    always_comb begin
        legal = 1'b0;
        case (burst_e'(burst))
            BURST_FIXED: legal = !size_bad_s && !fixed_len_bad_s;
            BURST_INCR:  legal = !size_bad_s && !incr_cross_s;
            BURST_WRAP:  legal = !size_bad_s && !wrap_len_bad_s && !wrap_align_bad_s;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address generator: latches a descriptor and emits one beat
// address per accepted beat with FIXED / INCR / WRAP semantics.
//   clk_i, arst_i    : clock, asynchronous active-high reset
//   start_i, addr_i, len_i, size_i, burst_i : descriptor (taken when idle)
//   flush_i          : synchronous abort back to idle
//   beat_ready_i     : consumer accepts the current beat
//   addr_o, beat_valid_o, last_o : current beat
//   busy_o, done_o, error_o      : status (done/error are one-cycle pulses)
module axi_burst_addr_gen
    import axi_burst_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int LEN_WIDTH      = 8,
    parameter int BOUNDARY_BYTES = BOUNDARY_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      start_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    input  logic [2:0]                size_i,
    input  logic [1:0]                burst_i,
    input  logic                      flush_i,
    input  logic                      beat_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] addr_o,
    output logic                      beat_valid_o,
    output logic                      last_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);

    localparam logic [AXI_ADDR_WIDTH-1:0] ONE_A  = AXI_ADDR_WIDTH'(1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ZERO_A = {AXI_ADDR_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]      ZERO_L = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]      ONE_L  = LEN_WIDTH'(1);

    state_e                    state_r,   state_nxt_s;
    burst_e                    burst_r,   burst_nxt_s;
    logic [AXI_ADDR_WIDTH-1:0] addr_r,    addr_nxt_s;
    logic [AXI_ADDR_WIDTH-1:0] incr_r,    incr_nxt_s;
    logic [AXI_ADDR_WIDTH-1:0] wrap_lo_r, wrap_lo_nxt_s;
    logic [AXI_ADDR_WIDTH-1:0] wrap_hi_r, wrap_hi_nxt_s;
    logic [LEN_WIDTH-1:0]      len_r,     len_nxt_s;
    logic [LEN_WIDTH-1:0]      cnt_r,     cnt_nxt_s;
    logic                      last_r,    last_nxt_s;
    logic                      done_r,    done_nxt_s;
    logic                      error_r,   error_nxt_s;

    logic                      legal_s;
    logic [AXI_ADDR_WIDTH-1:0] in_incr_s;
    logic [AXI_ADDR_WIDTH-1:0] in_wrap_bytes_s;
    logic [AXI_ADDR_WIDTH-1:0] in_wrap_lo_s;
    logic [AXI_ADDR_WIDTH-1:0] sum_s;
    logic [AXI_ADDR_WIDTH-1:0] step_addr_s;

    axi_burst_check #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .LEN_WIDTH      (LEN_WIDTH),
        .BOUNDARY_BYTES (BOUNDARY_BYTES)
    ) u_check (
        .addr  (addr_i),
        .len   (len_i),
        .size  (size_i),
        .burst (burst_i),
        .legal (legal_s)
    );

    // Wrap window is computed once at acceptance; the upper bound is stored
    // so the per-beat wrap test is a single compare.
    assign in_incr_s       = AXI_ADDR_WIDTH'(size_to_bytes(size_i));
    assign in_wrap_bytes_s = in_incr_s * (AXI_ADDR_WIDTH'(len_i) + ONE_A);
    assign in_wrap_lo_s    = addr_i & ~(in_wrap_bytes_s - ONE_A);
    assign sum_s           = addr_r + incr_r;

    // Address of the beat following the current one
    always_comb begin
        step_addr_s = addr_r;
        case (burst_r)
            BURST_FIXED: step_addr_s = addr_r;
            BURST_INCR:  step_addr_s = (addr_r & ~(incr_r - ONE_A)) + incr_r;
            BURST_WRAP:  step_addr_s = (sum_s == wrap_hi_r) ? wrap_lo_r : sum_s;
            default:     step_addr_s = addr_r;
        endcase
    end

    // Next-state and next-output logic; flush outranks the beat handshake,
    // which outranks descriptor acceptance
    always_comb begin
        state_nxt_s   = state_r;
        burst_nxt_s   = burst_r;
        addr_nxt_s    = addr_r;
        incr_nxt_s    = incr_r;
        wrap_lo_nxt_s = wrap_lo_r;
        wrap_hi_nxt_s = wrap_hi_r;
        len_nxt_s     = len_r;
        cnt_nxt_s     = cnt_r;
        last_nxt_s    = last_r;
        done_nxt_s    = 1'b0;
        error_nxt_s   = 1'b0;
        if (flush_i) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = ZERO_L;
            last_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i && legal_s) begin
                        state_nxt_s   = ST_ACTIVE;
                        burst_nxt_s   = burst_e'(burst_i);
                        addr_nxt_s    = addr_i;
                        incr_nxt_s    = in_incr_s;
                        wrap_lo_nxt_s = in_wrap_lo_s;
                        wrap_hi_nxt_s = in_wrap_lo_s + in_wrap_bytes_s;
                        len_nxt_s     = len_i;
                        cnt_nxt_s     = ZERO_L;
                        last_nxt_s    = (len_i == ZERO_L);
                    end else if (start_i) begin
                        error_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (beat_ready_i && last_r) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = ZERO_L;
                        last_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else if (beat_ready_i) begin
                        cnt_nxt_s  = cnt_r + ONE_L;
                        last_nxt_s = ((cnt_r + ONE_L) == len_r);
                        addr_nxt_s = step_addr_s;
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = ZERO_L;
                    last_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched descriptor, beat counter and registered outputs
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            burst_r   <= BURST_FIXED;
            addr_r    <= ZERO_A;
            incr_r    <= ZERO_A;
            wrap_lo_r <= ZERO_A;
            wrap_hi_r <= ZERO_A;
            len_r     <= ZERO_L;
            cnt_r     <= ZERO_L;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            burst_r   <= burst_nxt_s;
            addr_r    <= addr_nxt_s;
            incr_r    <= incr_nxt_s;
            wrap_lo_r <= wrap_lo_nxt_s;
            wrap_hi_r <= wrap_hi_nxt_s;
            len_r     <= len_nxt_s;
            cnt_r     <= cnt_nxt_s;
            last_r    <= last_nxt_s;
            done_r    <= done_nxt_s;
            error_r   <= error_nxt_s;
        end
    end

    assign addr_o       = addr_r;
    assign busy_o       = (state_r == ST_ACTIVE);
    assign beat_valid_o = busy_o;
    assign last_o       = last_r;
    assign done_o       = done_r;
    assign error_o      = error_r;

endmodule
